// File: rtl/operand_gen_pkg.sv
// operand_gen_pkg: shared FSM states, corner operand pairs and the LFSR safe seed for operand_gen.
package operand_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH_A,
        S_FETCH_B,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [31:0] LFSR_SAFE_SEED = 32'h0000_0001;

    // Index 0 is the first corner pair issued.
    localparam logic [3:0][31:0] CORNER_A = {32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [3:0][31:0] CORNER_B = {32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

endpackage

// File: rtl/operand_gen.sv
// operand_gen: seeds/steps an external LFSR and issues (A, B) operand pairs over valid/ready.
// Define OPERAND_GEN_CORNER_EN to prefix every run with four fixed corner pairs.
module operand_gen
    import operand_gen_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [31:0] i_seed,
    output logic        o_rnd_reset,
    output logic        o_rnd_enable,
    output logic [31:0] o_rnd_initial,
    input  logic [31:0] i_rnd,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic        o_busy,
    output logic [31:0] o_count
);

    localparam logic [31:0] LAST_IDX = 32'(NUM_VECTORS - 1);

    state_t      r_state, w_next;
    logic [31:0] r_seed, r_a, r_b, r_count;
    logic        w_start, w_hs, w_final, w_corner;

    assign w_start = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_hs    = r_state == S_PRESENT && i_ready;
    assign w_final = NUM_VECTORS != 0 && r_count == LAST_IDX;

`ifdef OPERAND_GEN_CORNER_EN
    logic [2:0] r_idx;
    assign w_corner = ~r_idx[2];
`else
    assign w_corner = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Corner pairs loop LOAD -> PRESENT; each LOAD reloads the seed so random vectors start from it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = i_start ? S_LOAD : r_state;
            S_LOAD:         w_next = w_corner ? S_PRESENT : S_FETCH_A;
            S_FETCH_A:      w_next = S_FETCH_B;
            S_FETCH_B:      w_next = S_PRESENT;
            S_PRESENT:      w_next = !i_ready ? S_PRESENT : w_final ? S_DONE : w_corner ? S_LOAD : S_FETCH_A;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seed  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_count <= '0;
`ifdef OPERAND_GEN_CORNER_EN
            r_idx   <= '0;
`endif
        end else begin
            if (w_start) begin
                r_seed  <= (i_seed == '0) ? LFSR_SAFE_SEED : i_seed;
                r_count <= '0;
            end
            if (r_state == S_FETCH_A) r_a <= i_rnd;
            if (r_state == S_FETCH_B) r_b <= i_rnd;
            if (w_hs) r_count <= r_count + 32'd1;
`ifdef OPERAND_GEN_CORNER_EN
            if (w_start) r_idx <= '0;
            else if (r_state == S_LOAD && w_corner) begin
                r_a   <= CORNER_A[r_idx[1:0]];
                r_b   <= CORNER_B[r_idx[1:0]];
                r_idx <= r_idx + 3'd1;
            end
`endif
        end
    end

    assign o_rnd_reset   = r_state == S_LOAD;
    assign o_rnd_enable  = r_state == S_FETCH_A || r_state == S_FETCH_B;
    assign o_rnd_initial = r_seed;
    assign o_a           = r_a;
    assign o_b           = r_b;
    assign o_valid       = r_state == S_PRESENT;
    assign o_last        = o_valid && w_final;
    assign o_busy        = !(r_state == S_IDLE || r_state == S_DONE);
    assign o_count       = r_count;

endmodule

// File: tb/tb_operand_gen.sv
// tb_operand_gen: scoreboard bench for operand_gen with behavioural Galois LFSRs at top level.
module tb_operand_gen;

`ifdef OPERAND_GEN_CORNER_EN
    localparam int NC = 4;
    localparam int NV = 5;
    localparam int LAT = 2;
`else
    localparam int NC = 0;
    localparam int NV = 2;
    localparam int LAT = 4;
`endif
    localparam logic [31:0] CA [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    localparam logic [31:0] CB [4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF};

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
    } vec_t;

    logic        clk = 0, reset_n = 0;
    logic        i_start = 0, i_ready = 0, f_start = 0, f_ready = 0;
    logic [31:0] i_seed = 0;
    logic        rnd_reset, rnd_enable, o_valid, o_last, o_busy;
    logic [31:0] rnd_initial, o_a, o_b, o_count, lfsr;
    logic        f_rnd_reset, f_rnd_enable, f_valid, f_last, f_busy;
    logic [31:0] f_rnd_initial, f_a, f_b, f_count, f_lfsr;
    logic [31:0] cap_a, cap_b;
    int          n_cmp = 0, n_bad = 0;
    vec_t        q[$];

    always #5 clk = ~clk;

    operand_gen #(.NUM_VECTORS(NV)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_seed(i_seed),
        .o_rnd_reset(rnd_reset), .o_rnd_enable(rnd_enable), .o_rnd_initial(rnd_initial),
        .i_rnd(lfsr), .o_a(o_a), .o_b(o_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_last(o_last), .o_busy(o_busy), .o_count(o_count)
    );

    operand_gen #(.NUM_VECTORS(0)) dut_free (
        .clk(clk), .reset_n(reset_n), .i_start(f_start), .i_seed(32'h1234_5678),
        .o_rnd_reset(f_rnd_reset), .o_rnd_enable(f_rnd_enable), .o_rnd_initial(f_rnd_initial),
        .i_rnd(f_lfsr), .o_a(f_a), .o_b(f_b), .o_valid(f_valid), .i_ready(f_ready),
        .o_last(f_last), .o_busy(f_busy), .o_count(f_count)
    );

    function automatic logic [31:0] nxt(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'hA300_0000) : (x >> 1);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        lfsr <= '0;
        else if (rnd_reset)  lfsr <= rnd_initial;
        else if (rnd_enable) lfsr <= nxt(lfsr);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          f_lfsr <= '0;
        else if (f_rnd_reset)  f_lfsr <= f_rnd_initial;
        else if (f_rnd_enable) f_lfsr <= nxt(f_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] seed, input int stall);
        logic [31:0] x, sa, sb, sc;
        int          cyc, k, g;
        vec_t        e;
        bit          first;
        x = (seed == 0) ? 32'h1 : seed;
        for (int v = 0; v < NV; v++) begin
            if (v < NC) e = '{CA[v], CB[v], v == NV - 1};
            else begin
                e = '{x, nxt(x), v == NV - 1};
                x = nxt(nxt(x));
            end
            q.push_back(e);
        end
        @(negedge clk);
        i_seed  = seed;
        i_start = 1;
        i_ready = (stall == 0);
        @(negedge clk);
        i_start = 0;
        chk("load_rst", rnd_reset, 1);
        chk("load_seed", rnd_initial, (seed == 0) ? 32'h1 : seed);
        cyc = 1;
        k = 0;
        first = 1;
        for (g = 0; g < 300 && q.size() > 0; g++) begin
            @(negedge clk);
            cyc++;
            if (o_valid) begin
                if (first) begin
                    chk("latency", cyc, LAT);
                    first = 0;
                    if (stall > 0) begin
                        sa = o_a; sb = o_b; sc = o_count;
                        repeat (stall) begin
                            @(negedge clk);
                            chk("stall_a", o_a, sa);
                            chk("stall_b", o_b, sb);
                            chk("stall_valid", o_valid, 1);
                            chk("stall_en", rnd_enable, 0);
                            chk("stall_cnt", o_count, sc);
                        end
                        i_ready = 1;
                    end
                end
                if (i_ready) begin
                    e = q.pop_front();
                    chk("vec_a", o_a, e.a);
                    chk("vec_b", o_b, e.b);
                    chk("vec_last", o_last, e.last);
                    chk("vec_cnt", o_count, k);
                    if (k == NC) begin
                        cap_a = o_a;
                        cap_b = o_b;
                    end
                    k++;
                end
            end
        end
        chk("run_timeout", q.size(), 0);
        @(negedge clk);
        chk("done_busy", o_busy, 0);
        chk("done_valid", o_valid, 0);
        chk("done_cnt", o_count, NV);
        repeat (2) @(negedge clk);
        chk("done_hold", o_count, NV);
    endtask

    initial begin
        int n, g;
        #12;
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_last", o_last, 0);
        chk("rst_cnt", o_count, 0);
        chk("rst_a", o_a, 0);
        chk("rst_b", o_b, 0);
        chk("rst_rrst", rnd_reset, 0);
        chk("rst_ren", rnd_enable, 0);
        chk("rst_init", rnd_initial, 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        i_start = 0;

        run(32'h1, 0);
        chk("seed1_a", cap_a, 32'h0000_0001);
        chk("seed1_b", cap_b, 32'hA300_0000);
        run(32'h0, 0);
        chk("seed0_a", cap_a, 32'h0000_0001);
        chk("seed0_b", cap_b, 32'hA300_0000);
        run(32'hDEAD_BEEF, 10);

        // Abort a run in FETCH_B with an asynchronous reset.
        @(negedge clk);
        i_seed = 32'h1; i_start = 1; i_ready = 1;
        @(negedge clk);
        i_start = 0;
        for (g = 0; g < 50 && !rnd_enable; g++) @(negedge clk);
        @(negedge clk);
        chk("fb_en", rnd_enable, 1);
        #1 reset_n = 0;
        #1;
        chk("ar_valid", o_valid, 0);
        chk("ar_busy", o_busy, 0);
        chk("ar_cnt", o_count, 0);
        chk("ar_a", o_a, 0);
        chk("ar_b", o_b, 0);
        chk("ar_ren", rnd_enable, 0);
        chk("ar_rrst", rnd_reset, 0);
        @(negedge clk);
        reset_n = 1;
        run(32'h1, 0);
        chk("rerun_a", cap_a, 32'h0000_0001);
        chk("rerun_b", cap_b, 32'hA300_0000);

        @(negedge clk);
        f_start = 1;
        f_ready = 1;
        @(negedge clk);
        f_start = 0;
        n = 0;
        for (g = 0; g < 4000 && n < 1000; g++) begin
            @(negedge clk);
            if (f_valid && f_ready) begin
                chk("free_last", f_last, 0);
                n++;
            end
        end
        chk("free_hs", n, 1000);
        @(negedge clk);
        f_ready = 0;
        @(negedge clk);
        chk("free_cnt", f_count, 1000);
        chk("free_busy", f_busy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
